// File: rtl/mac_ctrl_pkg.sv
// Shared encoding and default sizing for the MAC dot-product controller.
package mac_ctrl_pkg;

  localparam int K_DEF       = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int MAC_LAT_DEF = 1;
  localparam int STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_dot_ctrl.sv
// Sequences one MAC instance through a length-len dot product: clear, stream
// operand pairs with strobes, wait out the MAC pipeline, capture and report.
//
// state | meaning
// IDLE  | waiting for start; len is latched when start is seen
// CLEAR | one-cycle accumulator clear; picks RUN or, for len=0, DONE
// RUN   | op_ready high; each accepted pair is strobed into the MAC next cycle
// DRAIN | final strobe cycle plus MAC_LAT cycles until mac_out is complete
// DONE  | one-cycle done pulse with result valid
module mac_dot_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [K-1:0]     op_in,
  input  logic [K-1:0]     op_w,
  output logic [K-1:0]     mac_in,
  output logic [K-1:0]     mac_w,
  output logic             mac_ds_in,
  output logic             mac_ds_w,
  output logic             mac_clr,
  input  logic [2*K-1:0]   mac_out,
  output logic [2*K-1:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(MAC_LAT);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] pair_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             xfer;
  logic             last_pair;
  logic             drain_tc;

  // op_ready is only ever high in RUN, so it doubles as the RUN qualifier.
  assign xfer      = op_valid & op_ready;
  assign last_pair = xfer && (pair_cnt == (len_q - CNT_W'(1)));
  assign drain_tc  = (state == ST_DRAIN) && (drain_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (len_q != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (last_pair) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_tc) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      pair_cnt  <= '0;
      drain_cnt <= '0;
      mac_in    <= '0;
      mac_w     <= '0;
      mac_ds_in <= 1'b0;
      mac_ds_w  <= 1'b0;
      mac_clr   <= 1'b0;
      op_ready  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && start) len_q <= len;

      if (state == ST_CLEAR)
        pair_cnt <= '0;
      else if (xfer)
        pair_cnt <= pair_cnt + CNT_W'(1);

      // Down-counter loaded on DRAIN entry; the strobe cycle itself is the first count.
      if (state_nxt == ST_DRAIN && state != ST_DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DW'(1);

      if (xfer) begin
        mac_in <= op_in;
        mac_w  <= op_w;
      end
      mac_ds_in <= xfer;
      mac_ds_w  <= xfer;

      // Outputs are registered from the next state so they line up with it.
      mac_clr  <= (state_nxt == ST_CLEAR);
      op_ready <= (state_nxt == ST_RUN);
      done     <= (state_nxt == ST_DONE);
      busy     <= (state_nxt != ST_IDLE);

      if (state == ST_CLEAR && len_q == '0)
        result <= '0;
      else if (drain_tc)
        result <= mac_out;
    end
  end

endmodule
